// File: rtl/interleaved_window_reader.sv
// Read-side sequencer: raster-scans every I_WIDTH x I_WIDTH window of a tile through a 2-cycle RAM read
// port into a 4-deep FWFT FIFO. Define WINDOW_READER_COORD_EN to carry window coordinates with each entry.
module interleaved_window_reader #(
    parameter int I_WIDTH = 5,
    parameter int T_WIDTH = 32,
    parameter int D_SIZE  = 16,
    parameter int STRIDE  = 1,
    localparam int T_LOG  = $clog2(T_WIDTH),
    localparam int DW     = I_WIDTH * I_WIDTH * D_SIZE
) (
    input  logic             clkb,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [T_LOG-1:0] addrb_y,
    output logic [T_LOG-1:0] addrb_x,
    output logic             re,
    input  logic [DW-1:0]    doutb,
    output logic [DW-1:0]    win_data,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [T_LOG-1:0] win_y,
    output logic [T_LOG-1:0] win_x,
    output logic             win_last
);

    localparam int NPOS = (T_WIDTH - I_WIDTH) / STRIDE + 1;
    localparam logic [T_LOG-1:0] LAST_POS = T_LOG'((NPOS - 1) * STRIDE);
    localparam logic [T_LOG-1:0] STEP     = T_LOG'(STRIDE);
`ifdef WINDOW_READER_COORD_EN
    localparam int TAG_W = 2 * T_LOG + 1;
`else
    localparam int TAG_W = 1;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [T_LOG-1:0]   y_q, y_d, x_q, x_d;
    logic               done_q, done_d;
    logic               s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [TAG_W-1:0]   s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [DW-1:0]      data_mem_q [4];
    logic [DW-1:0]      data_mem_d [4];
    logic [TAG_W-1:0]   tag_mem_q [4];
    logic [TAG_W-1:0]   tag_mem_d [4];
    logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;

    logic [2:0]         inflight;
    logic               issue, at_last, push, pop;
    logic [TAG_W-1:0]   issue_tag, head_tag;

    // Credit rule: FIFO entries plus reads in flight never exceed the FIFO depth.
    assign inflight = {2'b00, s1_v_q} + {2'b00, s2_v_q};
    assign issue    = (state_q == SCAN) && ((count_q + inflight) < 3'd4);
    assign at_last  = (y_q == LAST_POS) && (x_q == LAST_POS);
    assign push     = s2_v_q;
    // Stream handshake: a window transfers on any edge where win_valid && win_ready;
    // the head entry is held unchanged while win_valid is high and win_ready is low.
    assign pop      = (count_q != 3'd0) && win_ready;

`ifdef WINDOW_READER_COORD_EN
    assign issue_tag = {y_q, x_q, at_last};
    assign win_y     = head_tag[2*T_LOG:T_LOG+1];
    assign win_x     = head_tag[T_LOG:1];
`else
    assign issue_tag = at_last;
    assign win_y     = '0;
    assign win_x     = '0;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        x_d     = x_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    y_d     = '0;
                    x_d     = '0;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (x_q == LAST_POS) begin
                        if (y_q == LAST_POS) begin
                            state_d = DRAIN;
                        end else begin
                            x_d = '0;
                            y_d = y_q + STEP;
                        end
                    end else begin
                        x_d = x_q + STEP;
                    end
                end
            end
            DRAIN: begin
                if (!s1_v_q && !s2_v_q && (count_q == 3'd0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_v_d     = issue;
        s1_tag_d   = issue_tag;
        s2_v_d     = s1_v_q;
        s2_tag_d   = s1_tag_q;
        data_mem_d = data_mem_q;
        tag_mem_d  = tag_mem_q;
        // doutb lines up with stage 2, so it is captured as that stage retires.
        if (push) begin
            data_mem_d[wr_ptr_q] = doutb;
            tag_mem_d[wr_ptr_q]  = s2_tag_q;
        end
        wr_ptr_d = wr_ptr_q + {1'b0, push};
        rd_ptr_d = rd_ptr_q + {1'b0, pop};
        count_d  = count_q + {2'b00, push} - {2'b00, pop};
    end

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            y_q      <= '0;
            x_q      <= '0;
            done_q   <= 1'b0;
            s1_v_q   <= 1'b0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_tag_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                data_mem_q[i] <= '0;
                tag_mem_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            x_q        <= x_d;
            done_q     <= done_d;
            s1_v_q     <= s1_v_d;
            s1_tag_q   <= s1_tag_d;
            s2_v_q     <= s2_v_d;
            s2_tag_q   <= s2_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_mem_q <= data_mem_d;
            tag_mem_q  <= tag_mem_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign re        = issue;
    assign addrb_y   = y_q;
    assign addrb_x   = x_q;
    assign win_valid = (count_q != 3'd0);
    assign win_data  = data_mem_q[rd_ptr_q];
    assign head_tag  = tag_mem_q[rd_ptr_q];
    assign win_last  = head_tag[0];

endmodule

// File: tb/tb_interleaved_window_reader.sv
// Bench for interleaved_window_reader: a default instance and a STRIDE=3 instance, each fed by a 2-cycle RAM
// model; a scoreboard queue holds expected {y, x, last} per window in raster order.
module tb_interleaved_window_reader;

    localparam int DW = 5 * 5 * 16;

    logic          clkb;
    logic          rst_n;
    logic          start0, start1, win_ready0, win_ready1;
    logic          busy0, busy1, done0, done1, re0, re1;
    logic          win_valid0, win_valid1, win_last0, win_last1;
    logic [4:0]    addrb_y0, addrb_x0, addrb_y1, addrb_x1;
    logic [4:0]    win_y0, win_x0, win_y1, win_x1;
    logic [DW-1:0] doutb0, doutb1, win_data0, win_data1;
    logic [9:0]    ra1_0, ra2_0, ra1_1, ra2_1;

    logic          sel;
    logic          mv, mr, mlast, mre, mbusy, mdone;
    logic [4:0]    my, mx, may, max;
    logic [DW-1:0] mdata;

    int            checks, errors, cyc;
    int            n_issue, n_pop, first_pop_cyc, last_pop_cyc;
    logic [10:0]   exp_q[$];
    logic [10:0]   mon_e;
    logic          hold_v, hold_last;
    logic [4:0]    hold_y, hold_x;
    logic [DW-1:0] hold_data;

    interleaved_window_reader #(.I_WIDTH(5), .T_WIDTH(32), .D_SIZE(16), .STRIDE(1)) u_dut0 (
        .clkb(clkb), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .addrb_y(addrb_y0), .addrb_x(addrb_x0), .re(re0), .doutb(doutb0),
        .win_data(win_data0), .win_valid(win_valid0), .win_ready(win_ready0),
        .win_y(win_y0), .win_x(win_x0), .win_last(win_last0)
    );

    interleaved_window_reader #(.I_WIDTH(5), .T_WIDTH(32), .D_SIZE(16), .STRIDE(3)) u_dut1 (
        .clkb(clkb), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .addrb_y(addrb_y1), .addrb_x(addrb_x1), .re(re1), .doutb(doutb1),
        .win_data(win_data1), .win_valid(win_valid1), .win_ready(win_ready1),
        .win_y(win_y1), .win_x(win_x1), .win_last(win_last1)
    );

    // Window at top-left (y, x): element [r][c] = ((y+r)<<8)|(x+c), row-major packing.
    function automatic logic [DW-1:0] win_fn(input logic [4:0] y, input logic [4:0] x);
        logic [DW-1:0] w;
        w = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[(r*5+c)*16 +: 16] = 16'(((int'(y) + r) << 8) | (int'(x) + c));
        return w;
    endfunction

    // clock/reset block and RAM models
    initial begin
        clkb = 1'b0;
        forever #5 clkb = ~clkb;
    end

    always_ff @(posedge clkb) begin
        cyc   <= cyc + 1;
        ra1_0 <= {addrb_y0, addrb_x0};
        ra2_0 <= ra1_0;
        ra1_1 <= {addrb_y1, addrb_x1};
        ra2_1 <= ra1_1;
    end
    assign doutb0 = win_fn(ra2_0[9:5], ra2_0[4:0]);
    assign doutb1 = win_fn(ra2_1[9:5], ra2_1[4:0]);

    assign mv    = sel ? win_valid1 : win_valid0;
    assign mr    = sel ? win_ready1 : win_ready0;
    assign mlast = sel ? win_last1  : win_last0;
    assign mre   = sel ? re1        : re0;
    assign mbusy = sel ? busy1      : busy0;
    assign mdone = sel ? done1      : done0;
    assign my    = sel ? win_y1     : win_y0;
    assign mx    = sel ? win_x1     : win_x0;
    assign may   = sel ? addrb_y1   : addrb_y0;
    assign max   = sel ? addrb_x1   : addrb_x0;
    assign mdata = sel ? win_data1  : win_data0;

    // scoreboard
    initial begin
        hold_v = 1'b0;
        forever begin
            @(negedge clkb);
            if (rst_n) begin
                if (mre) n_issue++;
                checks++;
                if (n_issue - n_pop > 4) begin
                    errors++;
                    $display("FAIL outstanding: got %0d need <= 4", n_issue - n_pop);
                end
                if (hold_v) begin
                    checks++;
                    if (!mv || mdata !== hold_data || mlast !== hold_last || my !== hold_y || mx !== hold_x) begin
                        errors++;
                        $display("FAIL stable: got valid=%0b y=%0d x=%0d last=%0b need valid=1 y=%0d x=%0d last=%0b",
                                 mv, my, mx, mlast, hold_y, hold_x, hold_last);
                    end
                end
                if (mv && mr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_window: got window with last=%0b, need none", mlast);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checks++;
                        if (mdata !== win_fn(mon_e[10:6], mon_e[5:1])) begin
                            errors++;
                            $display("FAIL data(%0d,%0d): got %h need %h", mon_e[10:6], mon_e[5:1],
                                     mdata, win_fn(mon_e[10:6], mon_e[5:1]));
                        end
                        checks++;
                        if (mlast !== mon_e[0]) begin
                            errors++;
                            $display("FAIL last(%0d,%0d): got %0b need %0b", mon_e[10:6], mon_e[5:1], mlast, mon_e[0]);
                        end
                        checks++;
`ifdef WINDOW_READER_COORD_EN
                        if (my !== mon_e[10:6] || mx !== mon_e[5:1]) begin
                            errors++;
                            $display("FAIL coord: got (%0d,%0d) need (%0d,%0d)", my, mx, mon_e[10:6], mon_e[5:1]);
                        end
`else
                        if (my !== 5'd0 || mx !== 5'd0) begin
                            errors++;
                            $display("FAIL coord: got (%0d,%0d) need (0,0)", my, mx);
                        end
`endif
                    end
                    if (n_pop == 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    n_pop++;
                end
                hold_v    = mv && !mr;
                hold_data = mdata;
                hold_last = mlast;
                hold_y    = my;
                hold_x    = mx;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic set_ready(input logic v);
        if (sel) win_ready1 = v;
        else     win_ready0 = v;
    endtask

    task automatic pulse_start();
        @(posedge clkb); #1;
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;
        @(posedge clkb); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic push_scan(input int npos, input int step);
        for (int yi = 0; yi < npos; yi++)
            for (int xi = 0; xi < npos; xi++)
                exp_q.push_back({5'(yi * step), 5'(xi * step), (yi == npos - 1) && (xi == npos - 1)});
    endtask

    task automatic clear_counts();
        exp_q.delete();
        n_issue = 0;
        n_pop   = 0;
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready=0
    task automatic run_until_done(input int mode, input int budget, output int done_cyc, output bit timed_out);
        timed_out = 1'b1;
        done_cyc  = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clkb); #1;
            case (mode)
                0:       set_ready(1'b1);
                1:       set_ready(1'($urandom_range(0, 1)));
                default: set_ready(1'b0);
            endcase
            @(negedge clkb);
            if (mdone) begin
                done_cyc  = cyc;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy0, done0, re0, win_valid0, win_last0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got busy=%0b done=%0b re=%0b valid=%0b last=%0b need all 0",
                     busy0, done0, re0, win_valid0, win_last0);
        end
        checks++;
        if (addrb_y0 !== 5'd0 || addrb_x0 !== 5'd0) begin
            errors++;
            $display("FAIL reset_addr: got (%0d,%0d) need (0,0)", addrb_y0, addrb_x0);
        end
        checks++;
        if (win_data0 !== '0 || win_y0 !== 5'd0 || win_x0 !== 5'd0) begin
            errors++;
            $display("FAIL reset_payload: got y=%0d x=%0d data=%h need 0", win_y0, win_x0, win_data0);
        end
        checks++;
        if ({busy1, done1, re1, win_valid1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_dut1: got busy=%0b done=%0b re=%0b valid=%0b need all 0", busy1, done1, re1, win_valid1);
        end
        @(posedge clkb); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_rate();
        int  first_k, dc;
        bit  to;
        sel = 1'b0;
        clear_counts();
        set_ready(1'b1);
        push_scan(28, 1);
        pulse_start();
        first_k = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clkb);
            if (k == 1) begin
                checks++;
                if (mre !== 1'b1 || may !== 5'd0 || max !== 5'd0 || mbusy !== 1'b1) begin
                    errors++;
                    $display("FAIL first_issue: got re=%0b busy=%0b addr=(%0d,%0d) need re=1 busy=1 addr=(0,0)",
                             mre, mbusy, may, max);
                end
            end
            if (mv && first_k == 0) first_k = k;
        end
        checks++;
        if (first_k != 4) begin
            errors++;
            $display("FAIL first_valid_latency: got cycle %0d need cycle 4", first_k);
        end
        run_until_done(0, 2000, dc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL done_timeout_full: got no done need done");
        end
        checks++;
        if (n_pop != 784 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL count_full: got %0d pops %0d left need 784 pops 0 left", n_pop, exp_q.size());
        end
        checks++;
        if (last_pop_cyc - first_pop_cyc != 783) begin
            errors++;
            $display("FAIL throughput: got %0d cycles need 783", last_pop_cyc - first_pop_cyc);
        end
        checks++;
        if (dc != last_pop_cyc + 2 || mbusy !== 1'b0) begin
            errors++;
            $display("FAIL done_timing: got done at +%0d busy=%0b need +2 busy=0", dc - last_pop_cyc, mbusy);
        end
        @(negedge clkb);
        checks++;
        if (mdone !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%0b need 0", mdone);
        end
    endtask

    task automatic test_backpressure();
        int dc;
        bit to;
        sel = 1'b0;
        clear_counts();
        push_scan(28, 1);
        pulse_start();
        run_until_done(1, 20000, dc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL done_timeout_random: got no done need done");
        end
        checks++;
        if (n_pop != 784 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL count_random: got %0d pops %0d left need 784 pops 0 left", n_pop, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int dc;
        bit to;
        sel = 1'b0;
        clear_counts();
        set_ready(1'b0);
        push_scan(28, 1);
        pulse_start();
        repeat (40) @(negedge clkb);
        checks++;
        if (n_issue != 4 || mre !== 1'b0) begin
            errors++;
            $display("FAIL stall_issues: got %0d re=%0b need 4 re=0", n_issue, mre);
        end
        checks++;
        if (mv !== 1'b1 || mdata !== win_fn(5'd0, 5'd0) || mlast !== 1'b0) begin
            errors++;
            $display("FAIL stall_head: got valid=%0b last=%0b data=%h need valid=1 last=0 data=%h",
                     mv, mlast, mdata, win_fn(5'd0, 5'd0));
        end
        run_until_done(0, 2000, dc, to);
        checks++;
        if (to || n_pop != 784 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_finish: got timeout=%0b pops=%0d left=%0d need 0 784 0", to, n_pop, exp_q.size());
        end
    endtask

    task automatic test_stride3();
        int dc;
        bit to;
        sel = 1'b1;
        clear_counts();
        set_ready(1'b1);
        push_scan(10, 3);
        pulse_start();
        run_until_done(0, 1000, dc, to);
        checks++;
        if (to || n_pop != 100 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stride3: got timeout=%0b pops=%0d left=%0d need 0 100 0", to, n_pop, exp_q.size());
        end
        checks++;
        if (dc != last_pop_cyc + 2) begin
            errors++;
            $display("FAIL stride3_done: got done at +%0d need +2", dc - last_pop_cyc);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int dc;
        bit to;
        sel = 1'b0;
        clear_counts();
        set_ready(1'b1);
        push_scan(28, 1);
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clkb); #1;
            if (n_pop >= 300) break;
        end
        checks++;
        if (n_pop < 300) begin
            errors++;
            $display("FAIL mid_reach: got %0d pops need 300", n_pop);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy0, done0, re0, win_valid0, win_last0} !== 5'b0 || addrb_y0 !== 5'd0 || addrb_x0 !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got busy=%0b done=%0b re=%0b valid=%0b last=%0b addr=(%0d,%0d) need 0",
                     busy0, done0, re0, win_valid0, win_last0, addrb_y0, addrb_x0);
        end
        checks++;
        if (win_data0 !== '0 || win_y0 !== 5'd0 || win_x0 !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset_payload: got y=%0d x=%0d data=%h need 0", win_y0, win_x0, win_data0);
        end
        @(posedge clkb); #1;
        rst_n = 1'b1;
        clear_counts();
        push_scan(28, 1);
        pulse_start();
        run_until_done(0, 2000, dc, to);
        checks++;
        if (to || n_pop != 784 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rescan: got timeout=%0b pops=%0d left=%0d need 0 784 0", to, n_pop, exp_q.size());
        end
    endtask

    task automatic test_start_held();
        int dc;
        bit to;
        sel = 1'b0;
        clear_counts();
        set_ready(1'b1);
        push_scan(28, 1);
        @(posedge clkb); #1;
        start0 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clkb); #1;
            if (n_pop >= 784) break;
        end
        start0 = 1'b0;
        run_until_done(0, 50, dc, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL held_done: got no done need done");
        end
        repeat (20) @(negedge clkb);
        checks++;
        if (n_pop != 784 || exp_q.size() != 0 || mbusy !== 1'b0) begin
            errors++;
            $display("FAIL held_count: got pops=%0d left=%0d busy=%0b need 784 0 0", n_pop, exp_q.size(), mbusy);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        n_issue    = 0;
        n_pop      = 0;
        sel        = 1'b0;
        start0     = 1'b0;
        start1     = 1'b0;
        win_ready0 = 1'b0;
        win_ready1 = 1'b0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_stall();
        test_stride3();
        test_reset_mid();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
